// File: rtl/cb_dequantizer.sv
`default_nettype none
// ============================================================================
//  Module      : cb_dequantizer
//  Description : Cb-channel JPEG inverse quantizer. Latches an 8x8 block of
//                quantized coefficients, multiplies one row per clock by the
//                quantization table (8 multipliers), then publishes the whole
//                block on Z at once (double-buffered output).
//  Revision    : 1.0  initial release
// ============================================================================
module cb_dequantizer #(
  parameter int USE_STD_TABLE = 0,  // 0: all-ones table, 1: Annex K.2 chroma table
  parameter int SAT_EN        = 1   // 1: saturate to signed 11 bit, 0: wrap
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [703:0]  Q_in,
  output logic [703:0]  Z,
  output logic          out_enable,
  output logic          busy,
  output logic          in_dropped
);

  localparam int C_N = 64;
  localparam int C_W = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [2:0]         r_row_cnt;
  logic               w_accept;
  logic               w_row_we;
  logic               w_publish;
  logic               r_out_enable;
  logic               r_busy;
  logic               r_in_dropped;

  logic signed [C_W-1:0] r_in_buf [0:C_N-1];
  logic signed [C_W-1:0] r_wk_buf [0:C_N-1];
  logic signed [C_W-1:0] r_z      [0:C_N-1];
  logic signed [C_W-1:0] w_res    [0:7];

  // Quantization table ROM lookup (8-bit unsigned entries).
  function automatic logic [7:0] f_tbl(input logic [2:0] r, input logic [2:0] c);
    logic [7:0] v;
    v = 8'd99;
    if (USE_STD_TABLE == 0) begin
      v = 8'd1;
    end else begin
      case (r)
        3'd0: case (c)
                3'd0: v = 8'd17;
                3'd1: v = 8'd18;
                3'd2: v = 8'd24;
                3'd3: v = 8'd47;
                default: v = 8'd99;
              endcase
        3'd1: case (c)
                3'd0: v = 8'd18;
                3'd1: v = 8'd21;
                3'd2: v = 8'd26;
                3'd3: v = 8'd66;
                default: v = 8'd99;
              endcase
        3'd2: case (c)
                3'd0: v = 8'd24;
                3'd1: v = 8'd26;
                3'd2: v = 8'd56;
                default: v = 8'd99;
              endcase
        3'd3: case (c)
                3'd0: v = 8'd47;
                3'd1: v = 8'd66;
                default: v = 8'd99;
              endcase
        default: v = 8'd99;
      endcase
    end
    return v;
  endfunction

  // One multiplier per column; all eight work on row r_row_cnt.
  for (genvar j = 0; j < 8; j++) begin : g_mul
    localparam logic [2:0] C_J = 3'(j);
    logic signed [C_W-1:0] w_a;
    logic [7:0]            w_q;
    logic signed [18:0]    w_p;

    assign w_a = r_in_buf[{r_row_cnt, C_J}];
    assign w_q = f_tbl(r_row_cnt, C_J);
    assign w_p = $signed({{8{w_a[C_W-1]}}, w_a}) * $signed({11'd0, w_q});

    // Clip to the signed 11-bit range, or keep the low bits when wrapping.
    always_comb begin
      w_res[j] = w_p[C_W-1:0];
      if (SAT_EN != 0) begin
        if (w_p > 19'sd1023) begin
          w_res[j] = 11'sd1023;
        end else if (w_p < -19'sd1024) begin
          w_res[j] = -11'sd1024;
        end
      end
    end
  end

  // Flatten the published block onto the output bus.
  for (genvar k = 0; k < C_N; k++) begin : g_pack
    assign Z[k*C_W +: C_W] = r_z[k];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_row_we     = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_accept     = 1'b1;
          w_next_state = S_PROC;
        end
      end
      S_PROC: begin
        w_row_we = 1'b1;
        if (r_row_cnt == 3'd7) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_publish    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Row counter, status pulses and the published output block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_cnt    <= 3'd0;
      r_out_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_in_dropped <= 1'b0;
      for (int k = 0; k < C_N; k++) begin
        r_z[k] <= '0;
      end
    end else begin
      r_out_enable <= 1'b0;
      r_in_dropped <= enable && (r_state != S_IDLE);
      if (w_accept) begin
        r_row_cnt <= 3'd0;
        r_busy    <= 1'b1;
      end
      if (w_row_we && (r_row_cnt != 3'd7)) begin
        r_row_cnt <= r_row_cnt + 3'd1;
      end
      if (w_publish) begin
        for (int k = 0; k < C_N; k++) begin
          r_z[k] <= r_wk_buf[k];
        end
        r_out_enable <= 1'b1;
        r_busy       <= 1'b0;
      end
    end
  end

  // Input and working buffers carry no reset: their contents only matter
  // after a block has been accepted and fully processed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < C_N; k++) begin
        r_in_buf[k] <= Q_in[k*C_W +: C_W];
      end
    end
    if (w_row_we) begin
      for (int j = 0; j < 8; j++) begin
        r_wk_buf[{r_row_cnt, 3'(j)}] <= w_res[j];
      end
    end
  end

  assign out_enable = r_out_enable;
  assign busy       = r_busy;
  assign in_dropped = r_in_dropped;

endmodule
`default_nettype wire

// File: tb/tb_cb_dequantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cb_dequantizer
//  Description : Self-checking bench for cb_dequantizer. Three instances
//                (identity table, standard table saturating, standard table
//                wrapping) share one stimulus stream; a transaction-level model
//                predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cb_dequantizer;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [703:0] Q_in;
  logic [703:0] z_d    [3];
  logic         oe_d   [3];
  logic         busy_d [3];
  logic         drop_d [3];

  always #5 clk = ~clk;

  cb_dequantizer #(.USE_STD_TABLE(0), .SAT_EN(1)) u_id (
    .clk(clk), .rst(rst), .enable(enable), .Q_in(Q_in), .Z(z_d[0]),
    .out_enable(oe_d[0]), .busy(busy_d[0]), .in_dropped(drop_d[0]));
  cb_dequantizer #(.USE_STD_TABLE(1), .SAT_EN(1)) u_std (
    .clk(clk), .rst(rst), .enable(enable), .Q_in(Q_in), .Z(z_d[1]),
    .out_enable(oe_d[1]), .busy(busy_d[1]), .in_dropped(drop_d[1]));
  cb_dequantizer #(.USE_STD_TABLE(1), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .Q_in(Q_in), .Z(z_d[2]),
    .out_enable(oe_d[2]), .busy(busy_d[2]), .in_dropped(drop_d[2]));

  int n_test = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int q [64];

  int TBL [64] = '{17, 18, 24, 47, 99, 99, 99, 99,
                   18, 21, 26, 66, 99, 99, 99, 99,
                   24, 26, 56, 99, 99, 99, 99, 99,
                   47, 66, 99, 99, 99, 99, 99, 99,
                   99, 99, 99, 99, 99, 99, 99, 99,
                   99, 99, 99, 99, 99, 99, 99, 99,
                   99, 99, 99, 99, 99, 99, 99, 99,
                   99, 99, 99, 99, 99, 99, 99, 99};

  // Reference dequantization: d=0 identity/sat, d=1 std/sat, d=2 std/wrap.
  function automatic int deq(input int v, input int k, input int d);
    int p;
    int t;
    t = (d == 0) ? 1 : TBL[k];
    p = v * t;
    if (d != 2) begin
      if (p > 1023)  p = 1023;
      if (p < -1024) p = -1024;
    end else begin
      p = p & 2047;
      if (p >= 1024) p = p - 2048;
    end
    return p;
  endfunction

  function automatic int zel(input logic [703:0] z, input int k);
    logic signed [10:0] e;
    e = z[k*11 +: 11];
    return int'(e);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_test++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int cyc = 0;
  bit m_busy;
  int m_acc;
  int exp_z [3][64];
  int pend  [3][64];
  bit exp_oe, exp_drop, exp_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 1'b0;
      exp_oe   = 1'b0;
      exp_drop = 1'b0;
      exp_busy = 1'b0;
      for (int d = 0; d < 3; d++)
        for (int k = 0; k < 64; k++) exp_z[d][k] = 0;
    end else begin
      exp_oe   = 1'b0;
      exp_drop = 1'b0;
      if (m_busy) begin
        if (enable) exp_drop = 1'b1;
        if (cyc == m_acc + 9) begin
          exp_z    = pend;
          exp_oe   = 1'b1;
          exp_busy = 1'b0;
          m_busy   = 1'b0;
        end
      end else if (enable) begin
        m_busy   = 1'b1;
        m_acc    = cyc;
        exp_busy = 1'b1;
        for (int d = 0; d < 3; d++)
          for (int k = 0; k < 64; k++)
            pend[d][k] = deq(zel(Q_in, k), k, d);
      end
    end
    if (!rst) cyc++;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        int bad;
        chk($sformatf("oe[%0d]", d),   int'(oe_d[d]),   int'(exp_oe));
        chk($sformatf("busy[%0d]", d), int'(busy_d[d]), int'(exp_busy));
        chk($sformatf("drop[%0d]", d), int'(drop_d[d]), int'(exp_drop));
        bad = -1;
        for (int k = 63; k >= 0; k--)
          if (zel(z_d[d], k) != exp_z[d][k]) bad = k;
        n_test++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL z[%0d] elem %0d: got %0d expected %0d",
                   d, bad, zel(z_d[d], bad), exp_z[d][bad]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_q();
    for (int k = 0; k < 64; k++) Q_in[k*11 +: 11] = 11'(q[k]);
  endtask

  // Called at a negedge; enable is sampled on the following posedge (E).
  task automatic pulse();
    set_q();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_oe(input int d, input string nm, output int n);
    n = 0;
    while (!oe_d[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({nm, "_timeout"}, n, -1);
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    enable = 1'b0;
    Q_in   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_d[1]), 0);
    chk("rst_oe",   int'(oe_d[1]), 0);
    chk("rst_z0",   zel(z_d[1], 0), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // T1: identity table returns the input block, 9 negedges after E
    for (int k = 0; k < 64; k++) q[k] = k - 32;
    pulse();
    wait_oe(0, "t1", n);
    chk("t1_latency", n, 9);
    chk("t1_z12", zel(z_d[0], 10), -22);

    // T2: all ones reproduces the table
    for (int k = 0; k < 64; k++) q[k] = 1;
    pulse();
    wait_oe(1, "t2", n);
    chk("t2_z00", zel(z_d[1], 0), 17);
    chk("t2_z31", zel(z_d[1], 25), 66);
    chk("t2_z77", zel(z_d[1], 63), 99);

    // T3: saturation and wrap corners
    for (int k = 0; k < 64; k++) q[k] = 0;
    q[0] = -1024; q[63] = 100; q[1] = -3;
    pulse();
    wait_oe(1, "t3", n);
    chk("t3_z00_sat",  zel(z_d[1], 0), -1024);
    chk("t3_z77_sat",  zel(z_d[1], 63), 1023);
    chk("t3_z01",      zel(z_d[1], 1), -54);
    chk("t3_z77_wrap", zel(z_d[2], 63), -340);

    // T4: second enable at E+4 is dropped; enable at E+10 accepted
    for (int k = 0; k < 64; k++) q[k] = k * 3 - 100;
    pulse();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 64; k++) q[k] = 7;
    pulse();
    chk("t4_drop", int'(drop_d[1]), 1);
    repeat (5) @(negedge clk);
    chk("t4_oe", int'(oe_d[0]), 1);
    chk("t4_first_blk", zel(z_d[0], 5), -85);
    for (int k = 0; k < 64; k++) q[k] = 2;
    pulse();
    wait_oe(1, "t4b", n);
    chk("t4_third_blk", zel(z_d[1], 0), 34);

    // T5: asynchronous reset mid-block
    for (int k = 0; k < 64; k++) q[k] = -5;
    pulse();
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", int'(busy_d[1]), 0);
    chk("t5_oe",   int'(oe_d[1]), 0);
    chk("t5_z0",   zel(z_d[1], 0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 64; k++) q[k] = 3;
    pulse();
    wait_oe(1, "t5b", n);
    chk("t5_after", zel(z_d[1], 9), 63);

    // T6: back-to-back blocks at E and E+10
    for (int k = 0; k < 64; k++) q[k] = k - 10;
    pulse();
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("t6_oe1", int'(oe_d[1]), 1);
    chk("t6_blk1", zel(z_d[1], 0), -170);
    for (int k = 0; k < 64; k++) q[k] = -2;
    pulse();
    wait_oe(1, "t6b", n);
    chk("t6_latency2", n, 9);
    chk("t6_blk2", zel(z_d[1], 0), -34);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
